// File: rtl/output_serializer_if.sv
// Bus between the serializer and its neighbours: block intake on one side,
// chunk output on the other, plus the sticky overrun flag.
//
// Handshake semantics (both sides follow strict valid/ready rules):
//   intake : pushin is the valid, ~busy is the ready. A block is taken on a
//            rising clk edge where pushin=1 and busy=0. pushin while busy=1
//            is dropped and raises overrun.
//   output : pushout is the valid, ~stopout is the ready. A chunk moves on a
//            rising clk edge where pushout=1 and stopout=0. While stopout=1,
//            dout/dox are held steady.
interface output_serializer_if;
    logic          pushin;
    logic [1599:0] din;
    logic          busy;
    logic          pushout;
    logic          stopout;
    logic [199:0]  dout;
    logic [2:0]    dox;
    logic          overrun;

    // Environment side: offers blocks, applies backpressure, watches output.
    modport master (
        output pushin,
        output din,
        output stopout,
        input  busy,
        input  pushout,
        input  dout,
        input  dox,
        input  overrun
    );

    // Serializer side.
    modport slave (
        input  pushin,
        input  din,
        input  stopout,
        output busy,
        output pushout,
        output dout,
        output dox,
        output overrun
    );
endinterface

// File: rtl/output_serializer.sv
// Splits a 1600-bit state block into NUM_CHUNKS chunks of 200 bits and emits
// them one per transfer, lowest index first. A new block can be accepted in
// the same cycle the last chunk leaves, so blocks stream back to back.
module output_serializer #(
    parameter int unsigned NUM_CHUNKS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output_serializer_if.slave   io,
    output logic                 dbg_send
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index of the final chunk of a block.
    localparam logic [2:0] LAST_IDX = 3'(NUM_CHUNKS - 1);

    state_t         state;
    logic [2:0]     idx;
    logic [1599:0]  holding;
    logic           pushout_q;
    logic [199:0]   dout_q;
    logic           overrun_q;

    logic           xfer;
    logic           last_xfer;
    logic           busy_c;
    logic           accept;
    logic           reject;

    // Select chunk k of a 1600-bit block.
    function automatic logic [199:0] chunk_of(input logic [1599:0] blk,
                                              input logic [2:0]    k);
        chunk_of = blk[int'(k) * 200 +: 200];
    endfunction

    // Handshake decode. busy drops during the final transfer so a waiting
    // block can be taken on the same edge; this gives busy a combinational
    // path from stopout.
    always_comb begin
        xfer      = 1'b0;
        last_xfer = 1'b0;
        busy_c    = 1'b0;
        accept    = 1'b0;
        reject    = 1'b0;
        xfer      = pushout_q & ~io.stopout;
        last_xfer = (state == SEND) && (idx == LAST_IDX) && !io.stopout;
        busy_c    = (state == SEND) && !last_xfer;
        accept    = io.pushin & ~busy_c;
        reject    = io.pushin & busy_c;
    end

    // FSM, holding register, chunk index and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            holding   <= '0;
            pushout_q <= 1'b0;
            dout_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            // A rejected push never touches the data path; it only latches
            // the overrun flag, which stays set until reset.
            if (reject) begin
                overrun_q <= 1'b1;
            end

            // accept is only possible in IDLE or during the final transfer,
            // so it always means "load a fresh block and start at chunk 0".
            if (accept) begin
                state     <= SEND;
                holding   <= io.din;
                idx       <= 3'd0;
                pushout_q <= 1'b1;
                dout_q    <= io.din[199:0];
            end else if (state == SEND && xfer) begin
                if (idx == LAST_IDX) begin
                    state     <= IDLE;
                    idx       <= 3'd0;
                    pushout_q <= 1'b0;
                    dout_q    <= '0;
                end else begin
                    idx    <= idx + 3'd1;
                    dout_q <= chunk_of(holding, idx + 3'd1);
                end
            end
        end
    end

    assign io.busy    = busy_c;
    assign io.pushout = pushout_q;
    assign io.dout    = dout_q;
    assign io.dox     = idx;
    assign io.overrun = overrun_q;
    assign dbg_send   = (state == SEND);

endmodule

// File: doc/output_serializer.md
OUTPUT_SERIALIZER -- requirements
Module: output_serializer

Interface
REQ-001 The block SHALL have parameter NUM_CHUNKS, default 8, giving the number of 200-bit chunks emitted per block; the legal range is 1..8.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous, active-low reset.
REQ-004 The block SHALL have port pushin, input, 1 bit, which offers a new 1600-bit state block.
REQ-005 The block SHALL have port din, input, 1600 bits, the state block; chunk k is din[200k+199:200k].
REQ-006 The block SHALL have port busy, output, 1 bit, which is high when a pushin would not be accepted this cycle.
REQ-007 The block SHALL have port pushout, output, 1 bit, which is high when a valid chunk is presented on dout/dox.
REQ-008 The block SHALL have port stopout, input, 1 bit, downstream backpressure; a chunk transfers only when pushout=1 and stopout=0.
REQ-009 The block SHALL have port dout, output, 200 bits, the current chunk.
REQ-010 The block SHALL have port dox, output, 3 bits, the index of the chunk on dout.
REQ-011 The block SHALL have port overrun, output, 1 bit, a sticky flag set by a rejected pushin.

Function
REQ-012 The block SHALL implement a two-state FSM: IDLE and SEND.
REQ-013 In IDLE, pushout SHALL be 0, busy SHALL be 0, and dox SHALL be 0.
REQ-014 When the block is in IDLE and pushin=1 at a clock edge, it SHALL capture din into a 1600-bit holding register, set the index to 0, and enter SEND.
REQ-015 Latency SHALL be as follows: pushout SHALL rise in the cycle immediately after the capturing edge, with dox=0 and dout=din[199:0] of the captured block.
REQ-016 In SEND, pushout SHALL be 1, dout SHALL be holding[200*idx+199:200*idx], and dox SHALL be idx.
REQ-017 When pushout=1 and stopout=1, idx, dout, dox and the holding register SHALL remain unchanged.
REQ-018 When a transfer occurs and idx < NUM_CHUNKS-1, idx SHALL increment by 1 at the edge.
REQ-019 When a transfer occurs and idx = NUM_CHUNKS-1, the FSM SHALL return to IDLE unless a new block is accepted in the same cycle (REQ-021).
REQ-020 busy SHALL be 1 in SEND, except in the cycle where the final chunk transfers (idx=NUM_CHUNKS-1, stopout=0), where busy SHALL be 0; busy therefore has a combinational path from stopout.
REQ-021 When pushin=1 and busy=0 in the final-transfer cycle, the new din SHALL be captured, idx SHALL reset to 0, and the FSM SHALL remain in SEND, giving back-to-back blocks with no idle cycle.
REQ-022 When pushin=1 and busy=1, the block SHALL ignore the data, leave the holding register untouched, and set overrun=1 at that edge.
REQ-023 overrun SHALL clear only on reset.
REQ-024 When NUM_CHUNKS=1, each block SHALL produce exactly one transfer with dox=0.
REQ-025 Chunks with index >= NUM_CHUNKS SHALL never be emitted.

Reset
REQ-026 While reset=0, the block SHALL immediately force FSM=IDLE, idx=0, pushout=0, busy=0, dox=0, dout=0, overrun=0, and holding register=0, independent of clk.
REQ-027 A reset asserted mid-block SHALL abandon the block; after release, no further chunks of that block SHALL appear.
REQ-028 After reset release, the first clock edge SHALL be able to accept pushin.

Verification
REQ-029 Basic send: NUM_CHUNKS=8, stopout=0, push din with chunk k = k+1 -> 8 consecutive pushout cycles with dox 0..7 and dout 1..8, then pushout=0.
REQ-030 Backpressure: stopout=1 for 3 cycles while dox=2 -> dout/dox hold at chunk 2 for those cycles; the sequence then continues at 3 with no chunk lost or duplicated.
REQ-031 Back-to-back: pushin held high with block B ready in the cycle dox=7 transfers -> the next cycle shows dox=0 with B's chunk 0, and overrun stays 0.
REQ-032 Overrun: pushin while dox=4 and stopout=0 -> data ignored, the original chunks 5..7 are emitted, and overrun=1 persists until reset.
REQ-033 Truncated output: NUM_CHUNKS=2 -> exactly two transfers (dox 0, 1), then IDLE with busy=0.
REQ-034 Mid-block reset: assert reset=0 at dox=3, asynchronously between edges -> outputs zero immediately; after release, pushout stays 0 until a new pushin.
